// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects, EPC capture and a
// circular return-address stack. All state updates on the falling edge of clk.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 STEP         = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h0000_0180,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic [WIDTH-1:0] link_addr,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    input  logic             exception,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic [WIDTH-1:0] epc,
    output logic             misaligned,
    output logic             ras_empty,
    output logic             ras_full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;    // next free slot; top entry sits at ras_ptr-1
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    ras_count;
    logic             ras_active;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc_next;

    assign pc_plus_step = pc + WIDTH'(STEP);
    assign misaligned   = (pc % WIDTH'(STEP)) != '0;
    assign ras_empty    = ras_count == '0;
    assign ras_full     = ras_count == CW'(RAS_DEPTH);
    assign top_idx      = ras_ptr - PW'(1);

    // Stack traffic only happens on a normal enabled cycle, whatever PC source wins.
    assign ras_active = enable && !exception && !eret;
    assign do_push    = ras_active && call;
    assign do_pop     = ras_active && ret && !ras_empty;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latches.
        pc_next  = pc;
        epc_next = epc;
        if (exception) begin
            epc_next = pc;
            pc_next  = EXC_VECTOR;
        end else if (eret) begin
            pc_next = epc;
        end else if (enable) begin
            if (branch_taken)  pc_next = branch_target;
            else if (jump)     pc_next = jump_target;
            else if (ret)      pc_next = ras_empty ? ret_target : ras_mem[top_idx];
            else               pc_next = pc_plus_step;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(negedge clk) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            epc       <= '0;
            ras_ptr   <= '0;
            ras_count <= '0;
        end else begin
            pc  <= pc_next;
            epc <= epc_next;
            if (do_push && !do_pop) begin
                ras_ptr <= ras_ptr + PW'(1);
                if (!ras_full) ras_count <= ras_count + CW'(1);
            end else if (do_pop && !do_push) begin
                ras_ptr   <= ras_ptr - PW'(1);
                ras_count <= ras_count - CW'(1);
            end
        end
    end

    // NOTE: stack storage is not reset; the count alone decides which entries are valid.
    always_ff @(negedge clk) begin
        if (!reset && do_push)
            ras_mem[do_pop ? top_idx : ras_ptr] <= link_addr;
    end
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed walk through the key scenarios,
// then randomized traffic compared against a queue-based reference model.
module tb_pc_unit;
    localparam int          WIDTH = 32;
    localparam int          STEP  = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] EV    = 32'h0000_0180;

    logic clk = 1'b0;
    logic reset, enable, branch_taken, jump, call, ret, exception, eret;
    logic [WIDTH-1:0] branch_target, jump_target, link_addr, ret_target;
    logic [WIDTH-1:0] pc, pc_plus_step, epc;
    logic misaligned, ras_empty, ras_full;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_pc, m_epc;
    logic [WIDTH-1:0] m_ras[$];

    pc_unit #(
        .WIDTH(WIDTH), .STEP(STEP), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .call(call), .link_addr(link_addr),
        .ret(ret), .ret_target(ret_target),
        .exception(exception), .eret(eret),
        .pc(pc), .pc_plus_step(pc_plus_step), .epc(epc),
        .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 0; enable = 1; branch_taken = 0; jump = 0; call = 0; ret = 0;
        exception = 0; eret = 0;
        branch_target = '0; jump_target = '0; link_addr = '0; ret_target = '0;
    endtask

    // Reference: apply the priority rules to the pre-edge model state.
    task automatic model_step();
        logic [WIDTH-1:0] popped;
        if (reset) begin
            m_pc = RV; m_epc = '0; m_ras.delete();
        end else if (exception) begin
            m_epc = m_pc; m_pc = EV;
        end else if (eret) begin
            m_pc = m_epc;
        end else if (enable) begin
            popped = ret_target;
            if (ret && m_ras.size() > 0) popped = m_ras.pop_back();
            if (call) begin
                m_ras.push_back(link_addr);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            if (branch_taken)  m_pc = branch_target;
            else if (jump)     m_pc = jump_target;
            else if (ret)      m_pc = popped;
            else               m_pc = m_pc + WIDTH'(STEP);
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
        check("pc", pc, m_pc);
        check("epc", epc, m_epc);
        check("pc_plus_step", pc_plus_step, m_pc + WIDTH'(STEP));
        check("misaligned", 32'(misaligned), 32'((m_pc % STEP) != 0));
        check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        check("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
        idle();
    endtask

    initial begin
        idle();
        m_pc = 'x; m_epc = 'x;

        // Reset held for two edges, then sequential advance and stall.
        reset = 1; tick();
        reset = 1; tick();
        check("reset_pc", pc, 32'h0);
        check("reset_empty", 32'(ras_empty), 32'd1);
        tick(); check("adv1", pc, 32'd4);
        tick(); check("adv2", pc, 32'd8);
        tick(); check("adv3", pc, 32'd12);
        enable = 0; tick();
        enable = 0; tick(); check("hold", pc, 32'd12);

        // Branch beats jump.
        jump = 1; jump_target = 32'h10; tick();
        branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80; tick();
        check("br_over_jump", pc, 32'h40);
        tick(); check("after_branch", pc, 32'h44);

        // Exception overrides stall; eret returns.
        jump = 1; jump_target = 32'h20; tick();
        enable = 0; exception = 1; tick();
        check("exc_pc", pc, 32'h180);
        check("exc_epc", epc, 32'h20);
        eret = 1; tick(); check("eret_pc", pc, 32'h20);

        // Overfill the RAS, then drain it.
        for (int i = 0; i < 5; i++) begin
            call = 1; link_addr = 32'h100 + 32'(4 * i); tick();
        end
        check("ras_full", 32'(ras_full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ret = 1; tick();
            check("ras_pop", pc, 32'h110 - 32'(4 * i));
        end
        check("ras_drained", 32'(ras_empty), 32'd1);
        ret = 1; ret_target = 32'h300; tick(); check("ret_empty", pc, 32'h300);

        // Simultaneous call and ret replaces the top.
        call = 1; link_addr = 32'h200; tick();
        call = 1; link_addr = 32'h500; ret = 1; tick(); check("call_ret", pc, 32'h200);
        ret = 1; tick(); check("ret_after_swap", pc, 32'h500);
        check("swap_empty", 32'(ras_empty), 32'd1);

        // Wrap, misalignment, reset during exception.
        jump = 1; jump_target = 32'hFFFF_FFFC; tick();
        tick(); check("wrap", pc, 32'h0);
        jump = 1; jump_target = 32'h6; tick(); check("misaligned", 32'(misaligned), 32'd1);
        exception = 1; tick();
        exception = 1; reset = 1; tick();
        check("rst_exc_pc", pc, 32'h0);
        check("rst_exc_epc", epc, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            exception     = ($urandom_range(0, 29) == 0);
            eret          = ($urandom_range(0, 24) == 0);
            enable        = ($urandom_range(0, 5) != 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            call          = ($urandom_range(0, 3) == 0);
            ret           = ($urandom_range(0, 3) == 0);
            branch_target = $urandom() & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jump_target   = $urandom() & 32'hFFFF_FFFC;
            link_addr     = $urandom() & 32'hFFFF_FFFC;
            ret_target    = $urandom() & 32'hFFFF_FFFC;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined core's fetch stage. It holds the fetch address, advances it sequentially, and applies stall, branch, jump, exception and exception-return redirects under a fixed priority. A small return-address stack (RAS) predicts `jr $ra` targets. The EPC register captures the faulting PC.

## Interface
Parameters:
- `WIDTH`, 32: address width in bits.
- `STEP`, 4: sequential increment in bytes.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `EXC_VECTOR`, 32'h0000_0180: PC value on exception.
- `RAS_DEPTH`, 4: return-address stack entries (power of two, ≥2).

Ports:
- `clk` in 1: clock. All state updates on the falling edge.
- `reset` in 1: synchronous, active-high, sampled on the falling edge.
- `enable` in 1: 1 = PC may advance or redirect; 0 = hold (stall).
- `branch_taken` in 1: resolved branch redirect.
- `branch_target` in WIDTH: target for `branch_taken`.
- `jump` in 1: unconditional jump redirect.
- `jump_target` in WIDTH: target for `jump`.
- `call` in 1: push `link_addr` onto the RAS (jal).
- `link_addr` in WIDTH: return address to push.
- `ret` in 1: pop the RAS and redirect to the popped value (jr $ra).
- `ret_target` in WIDTH: fallback target when `ret` finds the RAS empty.
- `exception` in 1: trap. Overrides stall.
- `eret` in 1: return from exception. Overrides stall.
- `pc` out WIDTH: current fetch address.
- `pc_plus_step` out WIDTH: `pc + STEP`, combinational, modulo 2^WIDTH.
- `epc` out WIDTH: saved exception PC.
- `misaligned` out 1: combinational, asserted when `pc` is not a multiple of STEP.
- `ras_empty` out 1: RAS holds 0 entries.
- `ras_full` out 1: RAS holds RAS_DEPTH entries.

## Operation
- Next-PC priority, evaluated each falling edge:
  1. `reset`
  2. `exception`
  3. `eret`
  4. `enable=0`: hold
  5. `branch_taken`
  6. `jump`
  7. `ret`
  8. sequential advance
- reset: `pc<=RESET_VECTOR`, `epc<=0`, RAS count<=0, RAS pointer<=0. Takes effect mid-stall or mid-exception.
- exception: `epc<=pc` (the pre-edge value), `pc<=EXC_VECTOR`. RAS unchanged. `call`/`ret` are ignored that cycle.
- eret (without exception): `pc<=epc`. `epc` unchanged. RAS unchanged.
- Hold: `pc`, `epc` and RAS all unchanged. `call`/`ret` are ignored.
- With `enable=1`, redirect targets load unmodified. No alignment correction; `misaligned` flags the result.
- Sequential advance: `pc<=pc+STEP`, wrapping at 2^WIDTH without a flag.
- RAS ops (only with `enable=1` and no exception/eret) are independent of which PC source wins:
  - `ret`, non-empty: pop top. PC uses the popped value if `ret` is the selected source.
  - `ret`, empty: PC uses `ret_target`. Count stays 0.
  - `call` alone: push `link_addr`. When full, the oldest entry is overwritten (circular) and count saturates at RAS_DEPTH.
  - `call` and `ret` together: pop then push, net replace of the top. Count unchanged; if empty, count becomes 1.
- `branch_taken` and `jump` together: branch wins.

## Timing
- Redirect latency: inputs are sampled at falling edge N; `pc` shows the new value right after edge N. No extra bubble.
- `pc_plus_step`, `misaligned`, `ras_empty` and `ras_full` are combinational from registered state.
- Reset outputs: `pc=RESET_VECTOR`, `pc_plus_step=RESET_VECTOR+STEP`, `epc=0`, `ras_empty=1`, `ras_full=0`, `misaligned=(RESET_VECTOR mod STEP≠0)`.
- `reset` held for several edges: outputs stay at reset values. Advance resumes on the first edge with `reset=0`.

## Test plan
- Reset then 3 edges with `enable=1`, no redirects -> `pc`=0, 4, 8, 12. Hold `enable=0` for 2 edges -> `pc` stays 12.
- `pc`=0x10; `branch_taken=1` to 0x40 and `jump=1` to 0x80 on the same edge -> `pc`=0x40. Next edge -> `pc`=0x44.
- `pc`=0x20, `enable=0`, `exception=1` -> `pc`=0x180, `epc`=0x20. Then `eret` -> `pc`=0x20.
- Push 5 calls (0x100, 0x104, …, 0x110) with RAS_DEPTH=4 -> `ras_full=1`. Four `ret` edges -> `pc`=0x110, 0x10C, 0x108, 0x104, then `ras_empty=1`. Fifth `ret` with `ret_target`=0x300 -> `pc`=0x300.
- One entry 0x200 on the RAS; `call`(0x500) and `ret` on the same edge -> `pc`=0x200. Next `ret` -> `pc`=0x500, `ras_empty=1`.
- `pc`=0xFFFF_FFFC, advance -> `pc`=0. `jump` to 0x6 -> `misaligned=1`. `reset` during an exception -> `pc`=0, `epc`=0.
